// File: rtl/sram_pattern_tester_if.sv
// sram_pattern_tester_if
//   Request/response bus between the pattern tester (master) and the SRAM
//   controller (slave).
//   req             master->slave  request valid
//   ready           slave->master  controller can accept a request
//   write_enable    master->slave  1=write, 0=read (valid while req)
//   addr            master->slave  request address
//   write_data      master->slave  write data
//   write_done      slave->master  one-cycle pulse per completed write
//   read_data       slave->master  returned read data
//   read_data_valid slave->master  one-cycle pulse, returns in request order
interface sram_pattern_tester_if #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
);
    logic                 req;
    logic                 ready;
    logic                 write_enable;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] write_data;
    logic                 write_done;
    logic [DATA_BITS-1:0] read_data;
    logic                 read_data_valid;

    modport master (
        output req, write_enable, addr, write_data,
        input  ready, write_done, read_data, read_data_valid
    );

    modport slave (
        input  req, write_enable, addr, write_data,
        output ready, write_done, read_data, read_data_valid
    );
endinterface

// File: rtl/sram_pattern_tester.sv
// sram_pattern_tester
//   Writes P(a) = a ^ seed to addresses 0..last_addr, waits for every write to
//   complete, reads the range back in order and compares each returned word.
//   clk, reset_n      clock, asynchronous active-low reset
//   start             pulse; accepted only in IDLE or DONE
//   seed, last_addr   test parameters, sampled on an accepted start
//   busy, done, pass  status (pass valid while done)
//   error_count       saturating mismatch count
//   fail_addr/data    address and read data of the first mismatch
//   bus               master side of the controller request/response bus
module sram_pattern_tester #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] seed,
    input  logic [ADDR_BITS-1:0] last_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_BITS:0]   error_count,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [DATA_BITS-1:0] fail_data,
    sram_pattern_tester_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WDRAIN,
        S_READ,
        S_RDRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_BITS-1:0] r_seed;
    logic [ADDR_BITS-1:0] r_last_addr;
    logic [ADDR_BITS-1:0] r_issue_addr;
    logic [ADDR_BITS:0]   r_rd_addr;
    logic [ADDR_BITS:0]   r_wdone_cnt;
    logic [ADDR_BITS:0]   r_err_cnt;
    logic [ADDR_BITS-1:0] r_fail_addr;
    logic [DATA_BITS-1:0] r_fail_data;

    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_at_last;
    logic [ADDR_BITS:0]   w_range;
    logic                 w_compare;
    logic                 w_mismatch;
    logic [DATA_BITS-1:0] w_exp_data;

    function automatic logic [DATA_BITS-1:0] pattern(
        input logic [ADDR_BITS-1:0] a,
        input logic [DATA_BITS-1:0] s
    );
        return DATA_BITS'(a) ^ s;
    endfunction

    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_accept   = bus.req && bus.ready;
    assign w_at_last  = (r_issue_addr == r_last_addr);
    // One bit wider than the address so last_addr = all-ones does not wrap.
    assign w_range    = {1'b0, r_last_addr} + (ADDR_BITS+1)'(1);
    assign w_compare  = bus.read_data_valid && (r_state == S_READ || r_state == S_RDRAIN);
    assign w_exp_data = pattern(r_rd_addr[ADDR_BITS-1:0], r_seed);
    assign w_mismatch = w_compare && (bus.read_data != w_exp_data);

    assign bus.addr       = r_issue_addr;
    assign bus.write_data = pattern(r_issue_addr, r_seed);

    assign busy        = (r_state == S_WRITE) || (r_state == S_WDRAIN) ||
                         (r_state == S_READ)  || (r_state == S_RDRAIN);
    assign done        = (r_state == S_DONE);
    assign pass        = done && (r_err_cnt == '0);
    assign error_count = r_err_cnt;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        bus.req          = 1'b0;
        bus.write_enable = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                bus.req          = 1'b1;
                bus.write_enable = 1'b1;
                if (w_accept && w_at_last) w_state_nxt = S_WDRAIN;
            end
            S_WDRAIN: begin
                if (r_wdone_cnt == w_range) w_state_nxt = S_READ;
            end
            S_READ: begin
                bus.req = 1'b1;
                if (w_accept && w_at_last) w_state_nxt = S_RDRAIN;
            end
            S_RDRAIN: begin
                if (r_rd_addr == w_range) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seed       <= '0;
            r_last_addr  <= '0;
            r_issue_addr <= '0;
            r_rd_addr    <= '0;
            r_wdone_cnt  <= '0;
            r_err_cnt    <= '0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
        end else if (w_start_ok) begin
            r_seed       <= seed;
            r_last_addr  <= last_addr;
            r_issue_addr <= '0;
            r_rd_addr    <= '0;
            r_wdone_cnt  <= '0;
            r_err_cnt    <= '0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
        end else begin
            // Wrapping issue_addr to 0 on the last acceptance leaves it ready
            // for the read phase; rd_addr is still 0 from start.
            if (w_accept) begin
                r_issue_addr <= w_at_last ? '0 : r_issue_addr + ADDR_BITS'(1);
            end
            if (bus.write_done && (r_state == S_WRITE || r_state == S_WDRAIN)) begin
                r_wdone_cnt <= r_wdone_cnt + (ADDR_BITS+1)'(1);
            end
            if (w_compare) begin
                r_rd_addr <= r_rd_addr + (ADDR_BITS+1)'(1);
            end
            if (w_mismatch) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + (ADDR_BITS+1)'(1);
                if (r_err_cnt == '0) begin
                    r_fail_addr <= r_rd_addr[ADDR_BITS-1:0];
                    r_fail_data <= bus.read_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_pattern_tester.sv
// tb_sram_pattern_tester
//   Behavioural SRAM responder plus scoreboard: each test pushes the expected
//   request stream and final result; a monitor pops and compares on every
//   accepted request and on the rising edge of done.
module tb_sram_pattern_tester;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] seed;
    logic [9:0] last_addr;
    logic       busy, done, pass;
    logic [10:0] error_count;
    logic [9:0] fail_addr;
    logic [7:0] fail_data;

    sram_pattern_tester_if #(.ADDR_BITS(10), .DATA_BITS(8)) bus ();

    sram_pattern_tester #(.ADDR_BITS(10), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .seed        (seed),
        .last_addr   (last_addr),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .error_count (error_count),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [9:0] addr; logic [7:0] data; } req_t;
    typedef struct { logic pass; logic [10:0] err; logic [9:0] fa; logic [7:0] fd; } res_t;

    req_t exp_req[$];
    res_t exp_res[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int unsigned cur_n = 0;

    // responder controls
    logic       toggle_mode = 1'b0;
    logic       corrupt_en  = 1'b0;
    logic [9:0] corrupt_addr = '0;
    logic [7:0] corrupt_val  = '0;
    logic [7:0] mem [0:1023];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing (t=%0t)", name, act, $time);
    endfunction

    // ---------------- responder: write_done 1 cycle, read data 2 cycles ----
    logic        s_acc, s_we;
    logic [9:0]  s_addr;
    logic [7:0]  s_wdata;
    int unsigned cyc = 0;
    int unsigned wq[$];
    int unsigned rq_due[$];
    logic [7:0]  rq_dat[$];

    initial begin
        bus.ready           = 1'b1;
        bus.write_done      = 1'b0;
        bus.read_data       = '0;
        bus.read_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            s_acc   = bus.req && bus.ready;
            s_we    = bus.write_enable;
            s_addr  = bus.addr;
            s_wdata = bus.write_data;
            @(posedge clk);
            #1;
            cyc++;
            if (s_acc) begin
                if (s_we) begin
                    mem[s_addr] = s_wdata;
                    wq.push_back(cyc);
                end else begin
                    rq_due.push_back(cyc + 1);
                    rq_dat.push_back((corrupt_en && s_addr == corrupt_addr) ? corrupt_val : mem[s_addr]);
                end
            end
            bus.write_done = 1'b0;
            if (wq.size() != 0 && wq[0] <= cyc) begin
                void'(wq.pop_front());
                bus.write_done = 1'b1;
            end
            bus.read_data_valid = 1'b0;
            if (rq_due.size() != 0 && rq_due[0] <= cyc) begin
                void'(rq_due.pop_front());
                bus.read_data       = rq_dat.pop_front();
                bus.read_data_valid = 1'b1;
            end
            bus.ready = toggle_mode ? ~bus.ready : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_hold = 1'b0;
    logic        prev_done = 1'b0;
    req_t        held;
    req_t        mon_e;
    res_t        mon_r;
    int unsigned wd_cnt = 0;
    int unsigned acc_w = 0, acc_r = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold = 1'b0;
            prev_done = 1'b0;
            wd_cnt    = 0;
        end else begin
            if (!busy) wd_cnt = 0;
            else if (bus.write_done) wd_cnt++;

            if (prev_hold) begin
                chk("hold_req", bus.req, 1'b1);
                chk("hold_fields", {bus.write_enable, bus.addr, bus.write_data},
                    {held.we, held.addr, held.data});
            end

            if (bus.req && bus.ready) begin
                if (exp_req.size() == 0) begin
                    fail_now("extra_req", {bus.write_enable, bus.addr});
                end else begin
                    mon_e = exp_req.pop_front();
                    chk("req_we", bus.write_enable, mon_e.we);
                    chk("req_addr", bus.addr, mon_e.addr);
                    if (mon_e.we) begin
                        chk("req_wdata", bus.write_data, mon_e.data);
                        acc_w++;
                    end else begin
                        chk("read_after_writes", wd_cnt, cur_n);
                        acc_r++;
                    end
                end
            end
            prev_hold = bus.req && !bus.ready;
            held.we   = bus.write_enable;
            held.addr = bus.addr;
            held.data = bus.write_data;

            if (done && !prev_done) begin
                if (exp_res.size() == 0) begin
                    fail_now("extra_done", {pass, error_count});
                end else begin
                    mon_r = exp_res.pop_front();
                    chk("pass", pass, mon_r.pass);
                    chk("error_count", error_count, mon_r.err);
                    chk("fail_addr", fail_addr, mon_r.fa);
                    chk("fail_data", fail_data, mon_r.fd);
                end
            end
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic [7:0] sd, input logic [9:0] la, input res_t r);
        req_t q;
        for (int unsigned a = 0; a <= la; a++) begin
            q.we = 1'b1; q.addr = a[9:0]; q.data = a[7:0] ^ sd;
            exp_req.push_back(q);
        end
        for (int unsigned a = 0; a <= la; a++) begin
            q.we = 1'b0; q.addr = a[9:0]; q.data = '0;
            exp_req.push_back(q);
        end
        exp_res.push_back(r);
        cur_n = la + 1;
    endtask

    task automatic pulse_start(input logic [7:0] sd, input logic [9:0] la);
        seed      = sd;
        last_addr = la;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, done, 1'b1);
        repeat (2) @(negedge clk);
        chk("reqs_left", exp_req.size(), 0);
        chk("results_left", exp_res.size(), 0);
        exp_req.delete();
        exp_res.delete();
    endtask

    task automatic run_test(input string name, input logic [7:0] sd, input logic [9:0] la,
                            input res_t r, input int unsigned budget);
        int unsigned w0, r0;
        w0 = acc_w;
        r0 = acc_r;
        push_expect(sd, la, r);
        pulse_start(sd, la);
        wait_done(name, budget);
        chk("n_writes", acc_w - w0, la + 1);
        chk("n_reads", acc_r - r0, la + 1);
    endtask

    res_t ok_res;
    res_t r;
    int unsigned k;
    int unsigned w0, r0;

    initial begin
        ok_res.pass = 1'b1; ok_res.err = '0; ok_res.fa = '0; ok_res.fd = '0;
        reset_n   = 1'b0;
        start     = 1'b0;
        seed      = '0;
        last_addr = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_we", bus.write_enable, 1'b0);
        chk("rst_addr_wdata", {bus.addr, bus.write_data}, 0);
        chk("rst_err_fail", {error_count, fail_addr, fail_data}, 0);
        reset_n = 1'b1;
        tick();

        // seed A5, 16 words, within 200 cycles
        run_test("t1_done", 8'hA5, 10'h00F, ok_res, 200);
        chk("t1_mem3", mem[3], 8'hA6);

        // corrupted read at 0x005 -> one error
        corrupt_en = 1'b1; corrupt_addr = 10'h005; corrupt_val = 8'h00;
        r.pass = 1'b0; r.err = 11'd1; r.fa = 10'h005; r.fd = 8'h00;
        run_test("t2_done", 8'h00, 10'h007, r, 400);
        corrupt_en = 1'b0;

        // ready toggling every cycle
        toggle_mode = 1'b1;
        run_test("t3_done", 8'h3C, 10'h01F, ok_res, 1000);
        toggle_mode = 1'b0;
        tick();

        // single location
        run_test("t4_done", 8'hFF, 10'h000, ok_res, 200);
        chk("t4_mem0", mem[0], 8'hFF);

        // reset in the middle of the read phase
        corrupt_en = 1'b1; corrupt_addr = 10'h001; corrupt_val = 8'h77;
        push_expect(8'h5A, 10'h00F, ok_res);
        pulse_start(8'h5A, 10'h00F);
        k = 0;
        while (!(bus.req && !bus.write_enable) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reached_read", bus.req && !bus.write_enable, 1'b1);
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk("t5_req", bus.req, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_err", error_count, 0);
        exp_req.delete();
        exp_res.delete();
        corrupt_en = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("t5_idle_after_stale", {busy, done, bus.req}, 0);
        run_test("t5b_done", 8'h5A, 10'h00F, ok_res, 400);

        // start while busy is ignored
        w0 = acc_w;
        r0 = acc_r;
        push_expect(8'h11, 10'h009, ok_res);
        pulse_start(8'h11, 10'h009);
        repeat (3) tick();
        pulse_start(8'h22, 10'h003);
        wait_done("t6_done", 400);
        chk("t6_writes", acc_w - w0, 10);
        chk("t6_reads", acc_r - r0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
